// File: rtl/fpu_issue_arb.sv
// fpu_issue_arb
//
// Round-robin arbiter and issue sequencer that shares one pipelined 16-bit
// FPU among NREQ requesters. One operation per cycle is accepted from the
// granted requester, registered, and driven to the FPU. A tag pipeline
// matched to the FPU latency remembers which requester owns each in-flight
// operation, so the result and flags can be returned tagged with that ID.
// A sticky OR of all returned flags is kept until cleared.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid[NREQ]            per-requester request valid
//   req_ready[NREQ]            one-hot grant (combinational)
//   req_op/req_a/req_b         packed per-requester op (2b) and operands (16b)
//   issue_en                   gates new grants; in-flight ops still finish
//   fpu_op_valid/_type/a/b     registered issue interface to the FPU
//   fpu_result/fpu_flags       FPU outputs, valid LAT cycles after issue
//   rsp_valid/id/result/flags  one-cycle tagged response, no backpressure
//   sticky_flags, flags_clr    accumulated flags and their synchronous clear

module fpu_issue_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic                 issue_en,
    output logic                 fpu_op_valid,
    output logic [1:0]           fpu_op_type,
    output logic [15:0]          fpu_a,
    output logic [15:0]          fpu_b,
    input  logic [15:0]          fpu_result,
    input  logic [4:0]           fpu_flags,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic [4:0]           sticky_flags,
    input  logic                 flags_clr
);

    // Round-robin priority pointer
    logic [IDW-1:0] ptr_q, ptr_d;

    // Arbitration results
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  scan_idx;
    logic            found;
    logic            handshake;

    // Issue registers feeding the FPU
    logic            op_valid_q, op_valid_d;
    logic [1:0]      op_type_q, op_type_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [IDW-1:0]  op_id_q, op_id_d;

    // Tag pipeline, one stage per cycle of FPU latency
    logic [LAT-1:0]  tag_valid_q, tag_valid_d;
    logic [IDW-1:0]  tag_id_q [LAT];
    logic [IDW-1:0]  tag_id_d [LAT];
    logic            tail_valid;
    logic [IDW-1:0]  tail_id;

    // Response and sticky registers
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic [4:0]      rsp_flags_q, rsp_flags_d;
    logic [4:0]      sticky_q, sticky_d;

    // Scan ptr, ptr+1, ... (mod NREQ) and grant the first valid requester.
    // The modulo keeps the scan correct for non-power-of-two NREQ.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        scan_idx = '0;
        found    = 1'b0;
        if (issue_en) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
                if (!found && req_valid[scan_idx]) begin
                    found           = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_id        = scan_idx;
                end
            end
        end
    end

    // Grants are only raised on valid requesters, so any grant is a handshake
    assign handshake = |grant;
    assign req_ready = grant;

    // Pointer advance and operand capture
    always_comb begin
        ptr_d      = ptr_q;
        op_valid_d = handshake;
        op_type_d  = op_type_q;
        a_d        = a_q;
        b_d        = b_q;
        op_id_d    = op_id_q;
        if (handshake) begin
            ptr_d     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            op_type_d = req_op[{grant_id, 1'b0} +: 2];
            a_d       = req_a[{grant_id, 4'b0000} +: 16];
            b_d       = req_b[{grant_id, 4'b0000} +: 16];
            op_id_d   = grant_id;
        end
    end

    // Stage 0 samples the op presented to the FPU this cycle; the tail
    // therefore lines up with the cycle the FPU result is valid.
    always_comb begin
        tag_valid_d    = '0;
        tag_valid_d[0] = op_valid_q;
        for (int i = 0; i < LAT; i++) begin
            tag_id_d[i] = '0;
        end
        tag_id_d[0] = op_id_q;
        for (int i = 1; i < LAT; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    assign tail_valid = tag_valid_q[LAT-1];
    assign tail_id    = tag_id_q[LAT-1];

    // Capture the FPU output when the tail is valid; otherwise hold.
    // A flag arriving in the same cycle as a clear survives the clear.
    always_comb begin
        rsp_valid_d  = tail_valid;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        sticky_d     = (flags_clr ? 5'b00000 : sticky_q) |
                       (tail_valid ? fpu_flags : 5'b00000);
        if (tail_valid) begin
            rsp_id_d     = tail_id;
            rsp_result_d = fpu_result;
            rsp_flags_d  = fpu_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            op_valid_q   <= 1'b0;
            op_type_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_id_q      <= '0;
            tag_valid_q  <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            sticky_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            op_valid_q   <= op_valid_d;
            op_type_q    <= op_type_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_id_q      <= op_id_d;
            tag_valid_q  <= tag_valid_d;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            sticky_q     <= sticky_d;
        end
    end

    assign fpu_op_valid = op_valid_q;
    assign fpu_op_type  = op_type_q;
    assign fpu_a        = a_q;
    assign fpu_b        = b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flags    = rsp_flags_q;
    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fpu_issue_arb.sv
// tb_fpu_issue_arb
//
// Testbench for fpu_issue_arb with NREQ=4, LAT=3. A behavioural stand-in
// FPU sits on the issue interface. A negedge scoreboard models the
// round-robin pointer, pushes the expected tagged response for every
// handshake and pops it in the cycle the response is due. Scenario tasks
// drive stimulus and check the scenario-specific values directly.

module tb_fpu_issue_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic                 issue_en;
    logic                 fpu_op_valid;
    logic [1:0]           fpu_op_type;
    logic [15:0]          fpu_a;
    logic [15:0]          fpu_b;
    logic [15:0]          fpu_result;
    logic [4:0]           fpu_flags;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_result;
    logic [4:0]           rsp_flags;
    logic [4:0]           sticky_flags;
    logic                 flags_clr;

    int n_compared;
    int n_mismatched;
    int cyc;

    typedef struct {
        int             due;
        logic [IDW-1:0] id;
        logic [15:0]    result;
        logic [4:0]     flags;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    fpu_issue_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .issue_en     (issue_en),
        .fpu_op_valid (fpu_op_valid),
        .fpu_op_type  (fpu_op_type),
        .fpu_a        (fpu_a),
        .fpu_b        (fpu_b),
        .fpu_result   (fpu_result),
        .fpu_flags    (fpu_flags),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Stand-in FPU: exact IEEE half results only for the operand pairs the
    // scenarios use (1+2, 1/0, 1/3); anything else returns a scrambled
    // pattern identifying the operands, with no flags. Idle slots carry a
    // poison value with every flag set so a response captured at the wrong
    // time corrupts rsp/sticky visibly.
    function automatic logic [20:0] fpu_model(input logic [1:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        if (op == 2'b11 && b[14:0] == 15'h0000)
            return {5'b01000, a[15] ^ b[15], 5'h1F, 10'h000};
        if (op == 2'b00 && a == 16'h3C00 && b == 16'h4000)
            return {5'b00000, 16'h4200};
        if (op == 2'b11 && a == 16'h3C00 && b == 16'h4200)
            return {5'b00001, 16'h3555};
        return {5'b00000, a ^ {b[7:0], b[15:8]} ^ {14'b0, op}};
    endfunction

    logic [20:0] fpu_pipe [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            fpu_pipe[i] <= fpu_pipe[i-1];
        end
        fpu_pipe[0] <= fpu_op_valid ? fpu_model(fpu_op_type, fpu_a, fpu_b)
                                    : {5'b11111, 16'hDEAD};
    end

    assign fpu_result = fpu_pipe[LAT-1][15:0];
    assign fpu_flags  = fpu_pipe[LAT-1][20:16];

    // Scoreboard / reference model, evaluated once per cycle at negedge
    initial begin : scoreboard
        int             m_ptr;
        int             m_gid;
        int             idx;
        logic [NREQ-1:0] m_grant;
        logic           m_fv;
        logic [1:0]     m_type;
        logic [15:0]    m_a;
        logic [15:0]    m_b;
        logic [4:0]     m_sticky;
        logic           m_clr_prev;
        logic [20:0]    m_res;
        sb_entry_t      e;
        m_ptr = 0; m_fv = 1'b0; m_type = '0; m_a = '0; m_b = '0;
        m_sticky = '0; m_clr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ptr = 0; m_fv = 1'b0; m_type = '0; m_a = '0; m_b = '0;
                m_sticky = '0; m_clr_prev = 1'b0;
                sb_q.delete();
            end
            m_grant = '0;
            m_gid   = 0;
            if (issue_en) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (m_grant == '0 && req_valid[idx]) begin
                        m_grant[idx] = 1'b1;
                        m_gid        = idx;
                    end
                end
            end
            n_compared++;
            if (req_ready !== m_grant) begin
                n_mismatched++;
                $display("[TB] FAIL sb_req_ready cyc=%0d: got %b want %b", cyc, req_ready, m_grant);
            end
            n_compared++;
            if ({fpu_op_valid, fpu_op_type, fpu_a, fpu_b} !== {m_fv, m_type, m_a, m_b}) begin
                n_mismatched++;
                $display("[TB] FAIL sb_fpu_issue cyc=%0d: got v=%b op=%b a=%h b=%h want v=%b op=%b a=%h b=%h",
                         cyc, fpu_op_valid, fpu_op_type, fpu_a, fpu_b, m_fv, m_type, m_a, m_b);
            end
            if (m_clr_prev) m_sticky = '0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                m_sticky = m_sticky | e.flags;
                n_compared++;
                if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, e.id, e.result, e.flags}) begin
                    n_mismatched++;
                    $display("[TB] FAIL sb_rsp cyc=%0d: got v=%b id=%0d res=%h fl=%b want v=1 id=%0d res=%h fl=%b",
                             cyc, rsp_valid, rsp_id, rsp_result, rsp_flags, e.id, e.result, e.flags);
                end
            end else begin
                n_compared++;
                if (rsp_valid !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL sb_rsp_idle cyc=%0d: got rsp_valid=%b want 0", cyc, rsp_valid);
                end
            end
            n_compared++;
            if (sticky_flags !== m_sticky) begin
                n_mismatched++;
                $display("[TB] FAIL sb_sticky cyc=%0d: got %b want %b", cyc, sticky_flags, m_sticky);
            end
            m_clr_prev = flags_clr;
            if (!reset && m_grant != '0) begin
                m_res    = fpu_model(req_op[2*m_gid +: 2], req_a[16*m_gid +: 16], req_b[16*m_gid +: 16]);
                e.due    = cyc + LAT + 2;
                e.id     = IDW'(m_gid);
                e.result = m_res[15:0];
                e.flags  = m_res[20:16];
                sb_q.push_back(e);
                m_fv   = 1'b1;
                m_type = req_op[2*m_gid +: 2];
                m_a    = req_a[16*m_gid +: 16];
                m_b    = req_b[16*m_gid +: 16];
                m_ptr  = (m_gid + 1) % NREQ;
            end else begin
                m_fv = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        req_op[2*i +: 2]  = op;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic test_reset();
        #2;
        n_compared++;
        if ({fpu_op_valid, fpu_op_type, fpu_a, fpu_b} !== 35'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_fpu: got v=%b op=%b a=%h b=%h want all 0", fpu_op_valid, fpu_op_type, fpu_a, fpu_b);
        end
        n_compared++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags, sticky_flags} !== 29'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_rsp: got v=%b id=%0d res=%h fl=%b st=%b want all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_flags, sticky_flags);
        end
        // req_ready stays combinational while reset is held
        issue_en  = 1'b1;
        req_valid = 4'b0110;
        #1;
        n_compared++;
        if (req_ready !== 4'b0010) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ready_comb: got %b want 0010", req_ready);
        end
        req_valid = 4'b0000;
        @(posedge clk);
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        int         rsp_seen;
        logic [3:0] exp_rdy;
        rsp_seen = 0;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 2'(i), 16'h1000 + 16'(i), 16'h2100 + 16'(i));
        end
        for (int k = 0; k < 16; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (k < 8) begin
                exp_rdy = 4'(1 << (k % 4));
                n_compared++;
                if (req_ready !== exp_rdy) begin
                    n_mismatched++;
                    $display("[TB] FAIL rr_grant k=%0d: got %b want %b", k, req_ready, exp_rdy);
                end
            end
            if (k >= 1 && k <= 8) begin
                n_compared++;
                if (fpu_op_valid !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL rr_op_valid k=%0d: got %b want 1", k, fpu_op_valid);
                end
            end
            if (rsp_valid) begin
                n_compared++;
                if (rsp_id !== 2'(rsp_seen % 4)) begin
                    n_mismatched++;
                    $display("[TB] FAIL rr_rsp_id n=%0d: got %0d want %0d", rsp_seen, rsp_id, rsp_seen % 4);
                end
                rsp_seen++;
            end
            next_cycle();
        end
        n_compared++;
        if (rsp_seen != 8) begin
            n_mismatched++;
            $display("[TB] FAIL rr_rsp_count: got %0d want 8", rsp_seen);
        end
    endtask

    task automatic test_issue_en();
        int         rsp_seen;
        logic [3:0] exp_rdy;
        rsp_seen = 0;
        for (int k = 0; k < 20; k++) begin
            req_valid = (k < 12) ? 4'hF : 4'h0;
            issue_en  = (k < 3 || k == 11);
            @(negedge clk);
            if (k < 3)       exp_rdy = 4'(1 << k);
            else if (k < 11) exp_rdy = 4'b0000;
            else if (k == 11) exp_rdy = 4'b1000;
            if (k <= 11) begin
                n_compared++;
                if (req_ready !== exp_rdy) begin
                    n_mismatched++;
                    $display("[TB] FAIL en_ready k=%0d: got %b want %b", k, req_ready, exp_rdy);
                end
            end
            if (k <= 10 && rsp_valid) rsp_seen++;
            if (k == 10) begin
                n_compared++;
                if (rsp_seen != 3) begin
                    n_mismatched++;
                    $display("[TB] FAIL en_rsp_count: got %0d want 3", rsp_seen);
                end
            end
            next_cycle();
        end
        issue_en = 1'b1;
    endtask

    task automatic test_single_op();
        set_req(0, 2'b00, 16'h3C00, 16'h4000);
        for (int k = 0; k < 8; k++) begin
            req_valid = (k == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (k == 0) begin
                n_compared++;
                if (req_ready !== 4'b0001) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_grant: got %b want 0001", req_ready);
                end
            end
            if (k == 1) begin
                n_compared++;
                if ({fpu_op_valid, fpu_op_type, fpu_a, fpu_b} !== {1'b1, 2'b00, 16'h3C00, 16'h4000}) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_issue: got v=%b op=%b a=%h b=%h want v=1 op=00 a=3c00 b=4000",
                             fpu_op_valid, fpu_op_type, fpu_a, fpu_b);
                end
            end
            if (k == 5) begin
                n_compared++;
                if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd0, 16'h4200, 5'b00000}) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_rsp: got v=%b id=%0d res=%h fl=%b want v=1 id=0 res=4200 fl=00000",
                             rsp_valid, rsp_id, rsp_result, rsp_flags);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_div_zero();
        set_req(2, 2'b11, 16'h3C00, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            req_valid = (k == 0) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (k == 0) begin
                n_compared++;
                if (req_ready !== 4'b0100) begin
                    n_mismatched++;
                    $display("[TB] FAIL div0_grant: got %b want 0100", req_ready);
                end
            end
            if (k == 5) begin
                n_compared++;
                if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd2, 16'h7C00, 5'b01000}) begin
                    n_mismatched++;
                    $display("[TB] FAIL div0_rsp: got v=%b id=%0d res=%h fl=%b want v=1 id=2 res=7c00 fl=01000",
                             rsp_valid, rsp_id, rsp_result, rsp_flags);
                end
            end
            if (k == 5 || k == 8) begin
                n_compared++;
                if (sticky_flags !== 5'b01000) begin
                    n_mismatched++;
                    $display("[TB] FAIL div0_sticky k=%0d: got %b want 01000", k, sticky_flags);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_flags_clr();
        set_req(1, 2'b11, 16'h3C00, 16'h4200);
        for (int k = 0; k < 9; k++) begin
            req_valid = (k == 0) ? 4'b0010 : 4'b0000;
            flags_clr = (k == 4 || k == 6);
            @(negedge clk);
            if (k == 0) begin
                n_compared++;
                if (req_ready !== 4'b0010) begin
                    n_mismatched++;
                    $display("[TB] FAIL clr_grant: got %b want 0010", req_ready);
                end
            end
            if (k == 5) begin
                n_compared++;
                if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd1, 16'h3555, 5'b00001}) begin
                    n_mismatched++;
                    $display("[TB] FAIL clr_rsp: got v=%b id=%0d res=%h fl=%b want v=1 id=1 res=3555 fl=00001",
                             rsp_valid, rsp_id, rsp_result, rsp_flags);
                end
                n_compared++;
                if (sticky_flags !== 5'b00001) begin
                    n_mismatched++;
                    $display("[TB] FAIL clr_same_cycle: got %b want 00001", sticky_flags);
                end
            end
            if (k == 7) begin
                n_compared++;
                if (sticky_flags !== 5'b00000) begin
                    n_mismatched++;
                    $display("[TB] FAIL clr_second: got %b want 00000", sticky_flags);
                end
            end
            next_cycle();
        end
        flags_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_req(0, 2'b01, 16'h1234, 16'h5678);
        set_req(1, 2'b10, 16'h4321, 16'h8765);
        for (int k = 0; k < 2; k++) begin
            req_valid = (k == 0) ? 4'b0001 : 4'b0010;
            @(negedge clk);
            n_compared++;
            if (req_ready !== req_valid) begin
                n_mismatched++;
                $display("[TB] FAIL rmid_grant k=%0d: got %b want %b", k, req_ready, req_valid);
            end
            next_cycle();
        end
        req_valid = 4'b0000;
        #1;
        reset = 1'b1;
        #1;
        n_compared++;
        if ({fpu_op_valid, fpu_op_type, fpu_a, fpu_b} !== 35'd0) begin
            n_mismatched++;
            $display("[TB] FAIL rmid_fpu: got v=%b op=%b a=%h b=%h want all 0", fpu_op_valid, fpu_op_type, fpu_a, fpu_b);
        end
        n_compared++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags, sticky_flags} !== 29'd0) begin
            n_mismatched++;
            $display("[TB] FAIL rmid_rsp: got v=%b id=%0d res=%h fl=%b st=%b want all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_flags, sticky_flags);
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_compared++;
            if (rsp_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL rmid_no_rsp k=%0d: got %b want 0", k, rsp_valid);
            end
            next_cycle();
        end
        req_valid = 4'b1010;
        @(negedge clk);
        n_compared++;
        if (req_ready !== 4'b0010) begin
            n_mismatched++;
            $display("[TB] FAIL rmid_ptr_reset: got %b want 0010", req_ready);
        end
        next_cycle();
        req_valid = 4'b0000;
        for (int k = 0; k < 8; k++) next_cycle();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        reset        = 1'b1;
        req_valid    = '0;
        req_op       = '0;
        req_a        = '0;
        req_b        = '0;
        issue_en     = 1'b0;
        flags_clr    = 1'b0;

        test_reset();
        test_round_robin();
        test_issue_en();
        test_single_op();
        test_div_zero();
        test_flags_clr();
        test_reset_mid();

        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fpu_issue_arb.md
Name: fpu_issue_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 16-bit FPU among NREQ requesters.
- Accepts one operation per cycle from the granted requester and drives the FPU operand and valid inputs.
- Tracks in-flight requester IDs through a tag pipeline matched to the FPU latency.
- Returns each result and its 5-bit flags tagged with the originating requester ID, and keeps a sticky OR of all returned flags.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, FPU latency: fpu_result/fpu_flags are valid exactly LAT cycles after the cycle fpu_op_valid is high (LAT >= 1).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, issue_en and the priority pointer.
- req_op  in  2*NREQ  op for requester i in [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 div.
- req_a  in  16*NREQ  operand A for requester i in [16i+15:16i].
- req_b  in  16*NREQ  operand B for requester i in [16i+15:16i].
- issue_en  in  1  when 0, no grants are issued; in-flight operations still complete.
- fpu_op_valid  out  1  to FPU op_valid.
- fpu_op_type  out  2  to FPU op_type.
- fpu_a  out  16  to FPU a.
- fpu_b  out  16  to FPU b.
- fpu_result  in  16  from FPU result.
- fpu_flags  in  5  from FPU flags: [4] invalid, [3] div-by-zero, [2] overflow, [1] underflow, [0] inexact.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_id  out  IDW  requester that issued the returned op.
- rsp_result  out  16  registered result.
- rsp_flags  out  5  registered flags.
- sticky_flags  out  5  accumulated OR of rsp flags.
- flags_clr  in  1  synchronous clear of sticky_flags.

Behaviour:
- Reset (asynchronous): all outputs 0 except req_ready, which follows its combinational equation; priority pointer = 0; tag pipeline emptied.
- Reset mid-operation: in-flight operations are discarded and produce no rsp_valid.
- Arbitration:
  - If issue_en = 1, grant the first i with req_valid[i] = 1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready = one-hot of that i; all zeros if no request or issue_en = 0.
  - A handshake is req_valid[i] & req_ready[i]. At most one handshake per cycle.
  - On a handshake with requester i, ptr <= (i+1) mod NREQ. ptr is unchanged on idle cycles.
- Issue:
  - Handshake in cycle C → in cycle C+1: fpu_op_valid = 1, and fpu_op_type/fpu_a/fpu_b = the granted requester's fields.
  - With no handshake, fpu_op_valid = 0 and the operand registers hold their value.
  - Back-to-back issue every cycle is supported.
- Tag pipeline:
  - LAT-stage shift register of {valid, id}, advancing every cycle.
  - The stage-0 entry loads in the cycle fpu_op_valid is high.
  - When the tail entry is valid (cycle C+1+LAT), register fpu_result and fpu_flags into rsp_result/rsp_flags, rsp_id <= tag id.
  - rsp_valid is high in cycle C+2+LAT: 5 cycles after the handshake for LAT = 3.
  - When no tail entry is valid, rsp_valid = 0 and rsp_result/rsp_flags/rsp_id hold.
- Ordering: responses return in issue order; the requester must not depend on anything else.
- Sticky flags:
  - sticky_flags <= (flags_clr ? 0 : sticky_flags) | (tail_valid ? fpu_flags : 0).
  - A flag set in the same cycle as flags_clr survives the clear.
- Invariants:
  - rsp_valid count equals handshake count (absent reset).
  - A requester holding req_valid is granted within NREQ cycles while issue_en = 1.
- issue_en deasserted mid-stream: operations already handshaken still produce responses.

Test Plan:
1. Single op: req0 add a=16'h3C00 (1.0), b=16'h4000 (2.0) → fpu_op_valid in cycle +1; rsp_valid 5 cycles after handshake with rsp_id=0, rsp_result=16'h4200, rsp_flags=0.
2. All four requesters valid continuously from reset → grants 0,1,2,3,0,1,... one per cycle; fpu_op_valid high every cycle; rsp_id sequence matches grant order with LAT+2 offset.
3. Div by zero from req2: a=16'h3C00, b=16'h0000, op=11 → rsp_flags[3]=1, rsp_result=16'h7C00; sticky_flags[3]=1 afterwards and stays 1 until flags_clr.
4. flags_clr asserted in the same cycle a response carrying inexact arrives → sticky_flags=5'b00001; with no new flags, the next flags_clr gives 0.
5. issue_en dropped one cycle after 3 back-to-back issues → req_ready=0 while low; exactly 3 rsp_valid pulses follow; the pointer resumes after the last granted requester.
6. Assert reset with 2 ops in flight → all outputs 0 immediately; no rsp_valid after release; the first grant after release goes to the lowest-index valid requester (ptr=0).
